// File: rtl/varredor_display_4.sv
// varredor_display_4: 4-digit multiplexed display scanner with frame-synchronous shadow load.
// Define APAGA_ZEROS_EN to enable leading-zero blanking on ativo.
module varredor_display_4 #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        atualiza,
    input  logic [15:0] digitos,
    output logic        B,
    output logic        A,
    output logic [3:0]  dado,
    output logic        ativo,
    output logic        passo,
    output logic        quadro,
    output logic        pendente
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pend_q, pend_d, passo_q, passo_d, quadro_q, quadro_d;
    logic          adv, wrap;
    always_comb begin
        adv      = en && (cnt_q == LAST);
        wrap     = adv && (sel_q == 2'd3);
        cnt_d    = !en ? cnt_q : (adv ? '0 : cnt_q + 1'b1);
        sel_d    = adv ? sel_q + 2'd1 : sel_q;
        shadow_d = (wrap && (pend_q || atualiza)) ? digitos : shadow_q;
        pend_d   = wrap ? 1'b0 : (pend_q || atualiza);
        passo_d  = adv;
        quadro_d = wrap;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            passo_q  <= 1'b0;
            quadro_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            passo_q  <= passo_d;
            quadro_q <= quadro_d;
        end
    end
    assign {B, A}   = sel_q;
    assign dado     = shadow_q[{sel_q, 2'b00} +: 4];
    assign passo    = passo_q;
    assign quadro   = quadro_q;
    assign pendente = pend_q;
`ifdef APAGA_ZEROS_EN
    // Blank when this nibble and all higher ones are zero; digit 0 is always shown.
    assign ativo = (sel_q == 2'd0) || (|(shadow_q >> {sel_q, 2'b00}));
`else
    assign ativo = 1'b1;
`endif
endmodule

// File: tb/tb_varredor_display_4.sv
// tb_varredor_display_4: randomized and directed checks of a DIV=4 and a DIV=1 scanner against a counting model.
module tb_varredor_display_4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        atualiza = 1'b0;
    logic [15:0] digitos = '0;
    logic [1:0]  b, a, at, pa, qu, pe;
    logic [7:0]  dd;
    int          tests = 0;
    int          fails = 0;
    int          divs [2] = '{4, 1};
    int          n [2];
    logic [15:0] m_sh [2];
    bit          m_pend [2], m_passo [2], m_quadro [2];

    varredor_display_4 #(.DIV(4)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .atualiza(atualiza), .digitos(digitos),
        .B(b[0]), .A(a[0]), .dado(dd[3:0]), .ativo(at[0]), .passo(pa[0]), .quadro(qu[0]), .pendente(pe[0]));
    varredor_display_4 #(.DIV(1)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .atualiza(atualiza), .digitos(digitos),
        .B(b[1]), .A(a[1]), .dado(dd[7:4]), .ativo(at[1]), .passo(pa[1]), .quadro(qu[1]), .pendente(pe[1]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_sel(input int i);
        return (n[i] / divs[i]) % 4;
    endfunction

    function automatic bit exp_ativo(input int i);
        int s = exp_sel(i);
        if (s == 0) return 1'b1;
`ifdef APAGA_ZEROS_EN
        for (int k = s; k < 4; k++)
            if (m_sh[i][4*k +: 4] != 4'h0) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            n[i] = 0; m_sh[i] = '0; m_pend[i] = 0; m_passo[i] = 0; m_quadro[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int s = exp_sel(i);
            check($sformatf("sel%0d", i), {b[i], a[i]}, s);
            check($sformatf("dado%0d", i), i ? dd[7:4] : dd[3:0], m_sh[i][4*s +: 4]);
            check($sformatf("passo%0d", i), pa[i], m_passo[i]);
            check($sformatf("quadro%0d", i), qu[i], m_quadro[i]);
            check($sformatf("pendente%0d", i), pe[i], m_pend[i]);
            check($sformatf("ativo%0d", i), at[i], exp_ativo(i));
        end
    endtask

    // One clock: apply inputs, advance the model on the edge, then compare.
    task automatic step(input bit e, input bit atu, input logic [15:0] dig);
        en = e; atualiza = atu; digitos = dig;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit bnd = 0;
            m_passo[i] = 0;
            if (e) begin
                n[i]++;
                m_passo[i] = (n[i] % divs[i]) == 0;
                bnd = (n[i] % (4 * divs[i])) == 0;
            end
            m_quadro[i] = bnd;
            if (bnd && (m_pend[i] || atu)) m_sh[i] = dig;
            m_pend[i] = bnd ? 1'b0 : (m_pend[i] || atu);
        end
        #1;
        check_all();
    endtask

    task automatic run_to_sel(input int s);
        for (int k = 0; k < 20 && exp_sel(0) != s; k++) step(1, 0, 16'hFFFF);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) step(1, 0, 16'hBEEF);
        run_to_sel(1);
        step(1, 1, 16'hDCBA);
        for (int k = 0; k < 20; k++) step(1, 0, 16'h5555);
        for (int k = 0; k < 20 && ((n[0] + 1) % 16) != 0; k++) step(1, 0, 16'h7777);
        step(1, 1, 16'h1234);
        for (int k = 0; k < 6; k++) step(1, 0, 16'h9999);
        run_to_sel(2);
        for (int k = 0; k < 10; k++) step(0, k == 2 || k == 6, k < 5 ? 16'h1111 : 16'h2222);
        for (int k = 0; k < 20; k++) step(1, 0, 16'h3333);
        for (int k = 0; k < 400; k++)
            step($urandom_range(9, 0) < 8, $urandom_range(9, 0) == 0, 16'($urandom));
        step(1, 1, 16'h0050);
        for (int k = 0; k < 20; k++) step(1, 0, 16'hAAAA);
        step(1, 1, 16'h0000);
        for (int k = 0; k < 20; k++) step(1, 0, 16'hAAAA);
        for (int k = 0; k < 20 && exp_sel(0) == 0; k++) step(1, 0, 16'h4321);
        step(1, 1, 16'h8765);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) step(1, 0, 16'h0F0F);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
